hs_mac_seq: RTL and testbench



---
 rtl/hs_mac_seq.sv | 169 ++++++++++++++++
 tb/tb_hs_mac_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_mac_seq.sv
// Iterative multiplier / multiply-accumulate with valid/ready handshakes.
// Multiplier digits (DIGIT bits per cycle) are consumed LSB first over WIDTH/DIGIT CALC cycles.
module hs_mac_seq #(
  parameter int WIDTH     = 8,
  parameter int DIGIT     = 2,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow,
  output logic                 busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int PW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AM = ACC_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [1:0] {MODE_MUL, MODE_MAC, MODE_RAW, MODE_CLR} mode_e;

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic                   sgn_q, sgn_d;
  logic                   neg_q, neg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          a_sh_q, a_sh_d;
  logic [WIDTH-1:0]       b_sh_q, b_sh_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [PW-1:0]          pp [DIGIT];
  logic [PW-1:0]          partial, prod_sum, prod_fin;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH:0]     mac_sum;
  logic                   mac_ovf;

  // One shifted copy of |a| per multiplier bit of the current digit.
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_pp
    assign pp[gi] = b_sh_q[gi] ? (a_sh_q << gi) : '0;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    // The most negative operand's magnitude still fits in WIDTH unsigned bits.
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    partial = '0;
    for (int i = 0; i < DIGIT; i++) begin
      partial = partial + pp[i];
    end
    prod_sum = prod_q + partial;
    prod_fin = neg_q ? -prod_sum : prod_sum;
    prod_ext = sgn_q ? ACC_WIDTH'($signed(prod_fin)) : ACC_WIDTH'(prod_fin);
    mac_sum  = {1'b0, acc_q} + {1'b0, prod_ext};
    mac_ovf  = sgn_q ? ((acc_q[AM] == prod_ext[AM]) && (mac_sum[AM] != acc_q[AM]))
                     : mac_sum[ACC_WIDTH];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d = mode_e'(mode);
          sgn_d  = is_signed;
          unique case (mode_e'(mode))
            MODE_MUL, MODE_MAC: begin
              a_sh_d  = PW'(a_mag);
              b_sh_d  = b_mag;
              prod_d  = '0;
              cnt_d   = '0;
              neg_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              state_d = CALC;
            end
            MODE_RAW: begin
              result_d = ACC_WIDTH'({b, a});
              state_d  = DONE;
            end
            default: begin
              acc_d    = '0;
              ovf_d    = 1'b0;
              result_d = '0;
              state_d  = DONE;
            end
          endcase
        end
      end
      CALC: begin
        prod_d = prod_sum;
        a_sh_d = a_sh_q << DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          state_d = DONE;
          if (mode_q == MODE_MAC) begin
            acc_d    = mac_sum[AM:0];
            ovf_d    = ovf_q | mac_ovf;
            result_d = mac_sum[AM:0];
          end else begin
            result_d = prod_ext;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_MUL;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_hs_mac_seq.sv
// Scoreboarded bench for hs_mac_seq: directed scenarios plus random commands
// checked against an integer-arithmetic reference model.
module tb_hs_mac_seq;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int AW = 2*W+4;
  localparam int N  = W/D;
  localparam longint MOD  = 64'sd1 << AW;
  localparam longint MASK = MOD - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic [1:0]    mode;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] result;
  logic          overflow;
  logic          busy;

  hs_mac_seq #(.WIDTH(W), .DIGIT(D), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ready_mode = 2;  // 0 random, 1 held low, 2 held high

  typedef struct {
    longint res;
    bit     ovf;
    int     lat;
    int     acc_cyc;
  } exp_t;
  exp_t exp_q[$];

  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: the architectural effect of one command, in plain arithmetic.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [1:0] mm, input logic ms);
    exp_t   e;
    longint p, s, sa;
    if (ms) p = longint'($signed(ma)) * longint'($signed(mb));
    else    p = longint'(ma) * longint'(mb);
    e.lat = N + 1;
    case (mm)
      2'd0: e.res = p & MASK;
      2'd1: begin
        if (ms) begin
          sa = (m_acc >= MOD/2) ? m_acc - MOD : m_acc;
          s  = sa + p;
          if (s >= MOD/2 || s < -(MOD/2)) m_ovf = 1'b1;
        end else begin
          s = m_acc + p;
          if (s >= MOD) m_ovf = 1'b1;
        end
        m_acc = s & MASK;
        e.res = m_acc;
      end
      2'd2: begin
        e.res = (longint'(mb) << W) | longint'(ma);
        e.lat = 1;
      end
      default: begin
        m_acc = 0;
        m_ovf = 1'b0;
        e.res = 0;
        e.lat = 1;
      end
    endcase
    e.ovf = m_ovf;
    e.acc_cyc = 0;
    return e;
  endfunction

  // All driver actions happen 1 time unit after a rising edge.
  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: in_ready=%0b, expected 1", in_ready);
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] tm,
                       input logic ts, input bit track);
    exp_t e;
    wait_idle();
    a = ta; b = tb_; mode = tm; is_signed = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (track) begin
      e = model(ta, tb_, tm, ts);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    $display("cmd mode=%0d signed=%0b a=0x%02h b=0x%02h", tm, ts, ta, tb_);
    chk("in_ready_after_accept", longint'(in_ready), 0);
    chk("busy_after_accept", longint'(busy), 1);
  endtask

  // Monitor: drives out_ready, then checks latency, hold stability and results.
  initial begin : monitor
    bit            prev_ov = 1'b0;
    logic [AW-1:0] prev_res = '0;
    exp_t          e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = (ready_mode == 2) ? 1'b1 : (ready_mode == 1) ? 1'b0 : ($urandom_range(2) != 0);
      if (!rst_n) begin
        prev_ov = 1'b0;
        continue;
      end
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: out_valid=1 with no command pending, expected 0");
        end else begin
          chk("latency", longint'(cyc - exp_q[0].acc_cyc + 1), longint'(exp_q[0].lat));
        end
      end
      if (out_valid && prev_ov) chk("result_hold", longint'(result), longint'(prev_res));
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("rsp result=0x%05h overflow=%0b (want 0x%05h/%0b)", result, overflow, e.res, e.ovf);
        chk("result", longint'(result), e.res);
        chk("overflow", longint'(overflow), longint'(e.ovf));
      end
      prev_ov  = out_valid && !out_ready;
      prev_res = result;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [W-1:0] ra, rb;
    logic [1:0]   rm;
    int           n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_result", longint'(result), 0);
    chk("reset_overflow", longint'(overflow), 0);
    chk("reset_busy", longint'(busy), 0);
    rst_n = 1'b1;

    // Basic MUL, signed corner cases, unsigned max.
    issue(8'd13, 8'd11, 2'd0, 1'b0, 1);
    issue(8'hFD, 8'h05, 2'd0, 1'b1, 1);
    issue(8'h80, 8'h80, 2'd0, 1'b1, 1);
    issue(8'hFF, 8'hFF, 2'd0, 1'b0, 1);
    issue(8'h80, 8'h7F, 2'd0, 1'b1, 1);

    // Accumulation.
    issue(8'd0, 8'd0, 2'd3, 1'b0, 1);
    issue(8'd2, 8'd3, 2'd1, 1'b0, 1);
    issue(8'd4, 8'd5, 2'd1, 1'b0, 1);
    issue(8'd6, 8'd7, 2'd1, 1'b0, 1);

    // Unsigned overflow on the 17th MAC, sticky until CLEAR.
    ready_mode = 0;
    issue(8'd0, 8'd0, 2'd3, 1'b0, 1);
    for (int i = 0; i < 17; i++) issue(8'hFF, 8'hFF, 2'd1, 1'b0, 1);
    issue(8'd1, 8'd1, 2'd0, 1'b0, 1);
    issue(8'h12, 8'h34, 2'd2, 1'b0, 1);
    issue(8'd0, 8'd0, 2'd3, 1'b0, 1);

    // Backpressure on a RAW result.
    wait_idle();
    ready_mode = 1;
    issue(8'h34, 8'h12, 2'd2, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_result", longint'(result), 64'h01234);
      chk("bp_in_ready", longint'(in_ready), 0);
      in_valid = ~in_valid;
      a = 8'($urandom); mode = 2'd2;
    end
    in_valid = 1'b0;
    ready_mode = 2;
    @(posedge clk); #1;
    chk("bp_in_ready_after", longint'(in_ready), 1);

    // Set overflow again, then reset in the middle of a MUL.
    ready_mode = 0;
    for (int i = 0; i < 17; i++) issue(8'hFF, 8'hFF, 2'd1, 1'b0, 1);
    wait_idle();
    ready_mode = 2;
    issue(8'h55, 8'h66, 2'd0, 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_acc = 0;
    m_ovf = 1'b0;
    chk("midreset_out_valid", longint'(out_valid), 0);
    chk("midreset_result", longint'(result), 0);
    chk("midreset_overflow", longint'(overflow), 0);
    chk("midreset_in_ready", longint'(in_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    issue(8'd1, 8'd1, 2'd1, 1'b0, 1);

    // Random commands.
    ready_mode = 0;
    for (int i = 0; i < 300; i++) begin
      n  = int'($urandom_range(15));
      rm = (n < 6) ? 2'd0 : (n < 12) ? 2'd1 : (n < 14) ? 2'd2 : 2'd3;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(7) == 0) ra = (ra[0]) ? 8'h80 : 8'h7F;
      if ($urandom_range(7) == 0) rb = (rb[0]) ? 8'h80 : 8'hFF;
      issue(ra, rb, rm, 1'($urandom), 1);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
